// File: rtl/ag_stage.sv
`default_nettype none
// ============================================================================
// ag_stage : address-generation stage with register scoreboard, store counter
//            and optional AG_PERF_CNT_EN dependency-stall counters.
// Rev 1.0
// ============================================================================
module ag_stage #(
  parameter int NREG   = 8,
  parameter int PEND_W = 2,
  parameter int ST_W   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_ag,
  input  logic        ag_vin,
  input  logic        de_re,
  input  logic        de_we,
  input  logic        de_rmsel,
  input  logic        ro_needed,
  input  logic        rm_needed,
  input  logic [1:0]  de_alusel,
  input  logic [2:0]  de_jmp,
  input  logic [7:0]  de_modrm,
  input  logic [15:0] de_sreg,
  input  logic [31:0] de_dval,
  input  logic [31:0] de_sval,
  input  logic [31:0] de_disp,
  output logic [2:0]  rf_ridx,
  input  logic [31:0] rf_rdata,
  input  logic        wb_v,
  input  logic        wb_rwe,
  input  logic [2:0]  wb_ridx,
  input  logic        st_done,
  output logic        reg_dep,
  output logic        mem_dep,
  output logic        ag_v,
  output logic        ag_re,
  output logic        ag_we,
  output logic        ag_rmsel,
  output logic [1:0]  ag_alusel,
  output logic [2:0]  ag_jmp,
  output logic [7:0]  ag_modrm,
  output logic [31:0] ag_dval,
  output logic [31:0] ag_sval,
  output logic [31:0] ag_addr,
  output logic [15:0] perf_regdep,
  output logic [15:0] perf_memdep
);

  localparam logic [PEND_W-1:0] c_pend_max = '1;
  localparam logic [ST_W-1:0]   c_st_max   = '1;

  logic              w_issue;
  logic              w_src_reg_v;
  logic              w_src_rm_v;
  logic              w_dst_v;
  logic              w_sb_inc;
  logic              w_sb_dec;
  logic              w_st_inc;
  logic              w_st_dec;
  logic [2:0]        w_reg_idx;
  logic [2:0]        w_rm_idx;
  logic [31:0]       w_addr;

  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic [ST_W-1:0]   st_cnt_q;
  logic [ST_W-1:0]   st_cnt_d;

  logic              ag_v_q;
  logic              ag_re_q;
  logic              ag_we_q;
  logic              ag_rmsel_q;
  logic [1:0]        ag_alusel_q;
  logic [2:0]        ag_jmp_q;
  logic [7:0]        ag_modrm_q;
  logic [31:0]       ag_dval_q;
  logic [31:0]       ag_sval_q;
  logic [31:0]       ag_addr_q;

  assign w_issue     = ld_ag & ag_vin;
  assign w_reg_idx   = de_modrm[5:3];
  assign w_rm_idx    = de_modrm[2:0];
  assign w_src_reg_v = ro_needed;
  assign w_src_rm_v  = rm_needed | de_rmsel;
  assign w_dst_v     = rm_needed & ~de_we & ~de_rmsel;
  assign rf_ridx     = w_rm_idx;

  // Segment base is the selector shifted left by four (real-mode style).
  assign w_addr = {12'h000, de_sreg, 4'h0} + rf_rdata + de_disp;

  // Stalls look only at decoded fields and current state, never at ld_ag/ag_vin.
  assign reg_dep = (w_src_reg_v & (pend_q[w_reg_idx] != '0))
                 | (w_src_rm_v  & (pend_q[w_rm_idx]  != '0))
                 | (w_dst_v     & (pend_q[w_rm_idx]  == c_pend_max));

  assign mem_dep = (de_re & (st_cnt_q != '0))
                 | (de_we & (st_cnt_q == c_st_max));

  assign w_sb_inc = w_issue & w_dst_v;
  assign w_sb_dec = wb_v & wb_rwe;
  assign w_st_inc = w_issue & de_we;
  assign w_st_dec = st_done;

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREG; i++) begin
      if (w_sb_inc && (w_rm_idx == 3'(i)) && !(w_sb_dec && (wb_ridx == 3'(i)))) begin
        if (pend_q[i] != c_pend_max) begin
          pend_d[i] = pend_q[i] + 1'b1;
        end
      end else if (w_sb_dec && (wb_ridx == 3'(i)) && !(w_sb_inc && (w_rm_idx == 3'(i)))) begin
        if (pend_q[i] != '0) begin
          pend_d[i] = pend_q[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    st_cnt_d = st_cnt_q;
    if (w_st_inc && !w_st_dec && (st_cnt_q != c_st_max)) begin
      st_cnt_d = st_cnt_q + 1'b1;
    end else if (w_st_dec && !w_st_inc && (st_cnt_q != '0)) begin
      st_cnt_d = st_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        pend_q[i] <= '0;
      end
      st_cnt_q <= '0;
    end else begin
      pend_q   <= pend_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  // A bubble clears only the valid; data fields keep the last issued op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ag_v_q      <= 1'b0;
      ag_re_q     <= 1'b0;
      ag_we_q     <= 1'b0;
      ag_rmsel_q  <= 1'b0;
      ag_alusel_q <= '0;
      ag_jmp_q    <= '0;
      ag_modrm_q  <= '0;
      ag_dval_q   <= '0;
      ag_sval_q   <= '0;
      ag_addr_q   <= '0;
    end else if (ld_ag) begin
      ag_v_q <= ag_vin;
      if (ag_vin) begin
        ag_re_q     <= de_re;
        ag_we_q     <= de_we;
        ag_rmsel_q  <= de_rmsel;
        ag_alusel_q <= de_alusel;
        ag_jmp_q    <= de_jmp;
        ag_modrm_q  <= de_modrm;
        ag_dval_q   <= de_dval;
        ag_sval_q   <= de_sval;
        ag_addr_q   <= w_addr;
      end
    end
  end

  assign ag_v      = ag_v_q;
  assign ag_re     = ag_re_q;
  assign ag_we     = ag_we_q;
  assign ag_rmsel  = ag_rmsel_q;
  assign ag_alusel = ag_alusel_q;
  assign ag_jmp    = ag_jmp_q;
  assign ag_modrm  = ag_modrm_q;
  assign ag_dval   = ag_dval_q;
  assign ag_sval   = ag_sval_q;
  assign ag_addr   = ag_addr_q;

`ifdef AG_PERF_CNT_EN
  logic [15:0] perf_reg_q;
  logic [15:0] perf_mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_reg_q <= '0;
      perf_mem_q <= '0;
    end else begin
      if (reg_dep && (perf_reg_q != 16'hFFFF)) begin
        perf_reg_q <= perf_reg_q + 16'd1;
      end
      if (mem_dep && (perf_mem_q != 16'hFFFF)) begin
        perf_mem_q <= perf_mem_q + 16'd1;
      end
    end
  end

  assign perf_regdep = perf_reg_q;
  assign perf_memdep = perf_mem_q;
`else
  assign perf_regdep = 16'h0000;
  assign perf_memdep = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ag_stage.sv
`default_nettype none
// ============================================================================
// tb_ag_stage : scoreboard bench for ag_stage with a behavioural model.
// Rev 1.0
// ============================================================================
module tb_ag_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_ag, ag_vin, de_re, de_we, de_rmsel, ro_needed, rm_needed;
  logic [1:0]  de_alusel;
  logic [2:0]  de_jmp;
  logic [7:0]  de_modrm;
  logic [15:0] de_sreg;
  logic [31:0] de_dval, de_sval, de_disp;
  logic [2:0]  rf_ridx;
  logic [31:0] rf_rdata;
  logic        wb_v, wb_rwe;
  logic [2:0]  wb_ridx;
  logic        st_done;
  logic        reg_dep, mem_dep;
  logic        ag_v, ag_re, ag_we, ag_rmsel;
  logic [1:0]  ag_alusel;
  logic [2:0]  ag_jmp;
  logic [7:0]  ag_modrm;
  logic [31:0] ag_dval, ag_sval, ag_addr;
  logic [15:0] perf_regdep, perf_memdep;

  ag_stage dut (
    .clk(clk), .rst_n(rst_n), .ld_ag(ld_ag), .ag_vin(ag_vin),
    .de_re(de_re), .de_we(de_we), .de_rmsel(de_rmsel),
    .ro_needed(ro_needed), .rm_needed(rm_needed),
    .de_alusel(de_alusel), .de_jmp(de_jmp), .de_modrm(de_modrm),
    .de_sreg(de_sreg), .de_dval(de_dval), .de_sval(de_sval), .de_disp(de_disp),
    .rf_ridx(rf_ridx), .rf_rdata(rf_rdata),
    .wb_v(wb_v), .wb_rwe(wb_rwe), .wb_ridx(wb_ridx), .st_done(st_done),
    .reg_dep(reg_dep), .mem_dep(mem_dep),
    .ag_v(ag_v), .ag_re(ag_re), .ag_we(ag_we), .ag_rmsel(ag_rmsel),
    .ag_alusel(ag_alusel), .ag_jmp(ag_jmp), .ag_modrm(ag_modrm),
    .ag_dval(ag_dval), .ag_sval(ag_sval), .ag_addr(ag_addr),
    .perf_regdep(perf_regdep), .perf_memdep(perf_memdep)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, vin, re, we, rmsel, ro, rm;
    logic [1:0]  alusel;
    logic [2:0]  jmp;
    logic [7:0]  modrm;
    logic [15:0] sreg;
    logic [31:0] dval, sval, disp;
    logic        wbv, wbrwe;
    logic [2:0]  wbidx;
    logic        std;
  } stim_t;

  typedef struct packed {
    logic        v, re, we, rmsel;
    logic [1:0]  alusel;
    logic [2:0]  jmp;
    logic [7:0]  modrm;
    logic [31:0] dval, sval, addr;
  } agexp_t;

  // Behavioural model state
  logic [31:0] rf_mem [8];
  int          pend_m [8];
  int          st_m;
  int          perf_r_m, perf_m_m;
  agexp_t      exp_q [$];
  bit          rf_churn;

  int n_vec = 0;
  int n_err = 0;

  always_comb rf_rdata = rf_mem[rf_ridx];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_regdep(input stim_t s);
    logic d;
    d = 1'b0;
    if (s.ro && pend_m[s.modrm[5:3]] > 0) d = 1'b1;
    if ((s.rm || s.rmsel) && pend_m[s.modrm[2:0]] > 0) d = 1'b1;
    if (s.rm && !s.we && !s.rmsel && pend_m[s.modrm[2:0]] == 3) d = 1'b1;
    return d;
  endfunction

  function automatic logic model_memdep(input stim_t s);
    return (s.re && st_m > 0) || (s.we && st_m == 7);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{ld: 1'b1, vin: 1'b0, re: 1'b0, we: 1'b0, rmsel: 1'b0, ro: 1'b0, rm: 1'b0,
          alusel: 2'd0, jmp: 3'd0, modrm: 8'h00, sreg: 16'h0000,
          dval: 32'h0, sval: 32'h0, disp: 32'h0,
          wbv: 1'b0, wbrwe: 1'b0, wbidx: 3'd0, std: 1'b0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s        = idle();
    s.ld     = ($urandom_range(0, 3) != 0);
    s.vin    = ($urandom_range(0, 3) != 0);
    s.re     = ($urandom_range(0, 3) == 0);
    s.we     = ($urandom_range(0, 2) == 0);
    s.rmsel  = ($urandom_range(0, 4) == 0);
    s.ro     = ($urandom_range(0, 1) == 1);
    s.rm     = ($urandom_range(0, 1) == 1);
    s.alusel = 2'($urandom);
    s.jmp    = 3'($urandom);
    s.modrm  = 8'($urandom);
    s.sreg   = 16'($urandom);
    s.dval   = $urandom;
    s.sval   = $urandom;
    s.disp   = $urandom;
    s.wbidx  = 3'($urandom);
    if ($urandom_range(0, 2) == 0 && pend_m[s.wbidx] > 0) begin
      s.wbv   = 1'b1;
      s.wbrwe = 1'b1;
    end else begin
      s.wbv = ($urandom_range(0, 3) == 0);
    end
    s.std = (st_m > 0) && ($urandom_range(0, 2) == 0);
    // Decode never presents an op that the stage reports as dependent.
    if (model_regdep(s) || model_memdep(s)) s.vin = 1'b0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    logic   rd, md, iss;
    agexp_t e;
    int     sp;
    @(negedge clk);
    if (rf_churn && $urandom_range(0, 3) == 0) rf_mem[$urandom_range(0, 7)] = $urandom;
    ld_ag = s.ld;        ag_vin = s.vin;      de_re = s.re;        de_we = s.we;
    de_rmsel = s.rmsel;  ro_needed = s.ro;    rm_needed = s.rm;
    de_alusel = s.alusel; de_jmp = s.jmp;     de_modrm = s.modrm;  de_sreg = s.sreg;
    de_dval = s.dval;    de_sval = s.sval;    de_disp = s.disp;
    wb_v = s.wbv;        wb_rwe = s.wbrwe;    wb_ridx = s.wbidx;   st_done = s.std;
    #1;
    rd = model_regdep(s);
    md = model_memdep(s);
    check("reg_dep", reg_dep, rd);
    check("mem_dep", mem_dep, md);
    check("rf_ridx", rf_ridx, s.modrm[2:0]);
`ifdef AG_PERF_CNT_EN
    check("perf_regdep", perf_regdep, 16'(perf_r_m));
    check("perf_memdep", perf_memdep, 16'(perf_m_m));
`else
    check("perf_off", {perf_regdep, perf_memdep}, 32'h0);
`endif
    assert (!(s.wbv && s.wbrwe && pend_m[s.wbidx] == 0))
      else $error("protocol: writeback to register %0d with nothing pending", s.wbidx);
    assert (!(s.std && st_m == 0))
      else $error("protocol: store retired with no store outstanding");
    iss = s.ld && s.vin;
    if (iss) begin
      e.v      = 1'b1;
      e.re     = s.re;
      e.we     = s.we;
      e.rmsel  = s.rmsel;
      e.alusel = s.alusel;
      e.jmp    = s.jmp;
      e.modrm  = s.modrm;
      e.dval   = s.dval;
      e.sval   = s.sval;
      e.addr   = 32'(s.sreg) * 32'd16 + rf_mem[s.modrm[2:0]] + s.disp;
      exp_q.push_back(e);
    end
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      int p;
      p = pend_m[i];
      if (iss && s.rm && !s.we && !s.rmsel && s.modrm[2:0] == 3'(i)) p++;
      if (s.wbv && s.wbrwe && s.wbidx == 3'(i)) p--;
      pend_m[i] = (p < 0) ? 0 : ((p > 3) ? 3 : p);
    end
    sp   = st_m + int'(iss && s.we) - int'(s.std);
    st_m = (sp < 0) ? 0 : ((sp > 7) ? 7 : sp);
    if (rd && perf_r_m < 65535) perf_r_m++;
    if (md && perf_m_m < 65535) perf_m_m++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) pend_m[i] = 0;
    st_m     = 0;
    perf_r_m = 0;
    perf_m_m = 0;
    exp_q.delete();
  endtask

  // Monitor: tracks what the AG registers must show and compares every cycle.
  initial begin : monitor
    agexp_t exp_ag, act;
    logic   issued, ld_s;
    exp_ag = '0;
    forever begin
      @(posedge clk);
      issued = ld_ag && ag_vin && rst_n;
      ld_s   = ld_ag;
      #1;
      if (!rst_n) begin
        exp_ag = '0;
      end else if (issued) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL ag_issue: got op with empty expectation queue, required none");
        end else begin
          exp_ag = exp_q.pop_front();
        end
      end else if (ld_s) begin
        exp_ag.v = 1'b0;
      end
      act = {ag_v, ag_re, ag_we, ag_rmsel, ag_alusel, ag_jmp, ag_modrm, ag_dval, ag_sval, ag_addr};
      check("ag_out", act, exp_ag);
    end
  end

  initial begin : main
    stim_t s;
    rst_n    = 1'b0;
    rf_churn = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) rf_mem[i] = $urandom;
    rf_mem[0] = 32'h0000_0010;
    s = idle();
    s.ld = 1'b0;
    ld_ag = 0; ag_vin = 0; de_re = 0; de_we = 0; de_rmsel = 0; ro_needed = 0; rm_needed = 0;
    de_alusel = 0; de_jmp = 0; de_modrm = 0; de_sreg = 0; de_dval = 0; de_sval = 0; de_disp = 0;
    wb_v = 0; wb_rwe = 0; wb_ridx = 0; st_done = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single store: address 0x10 + 0x10 + 0x1 = 0x21
    s = idle(); s.vin = 1; s.we = 1; s.sreg = 16'h0001; s.disp = 32'h1; s.modrm = 8'h00;
    apply(s);
    // Load waits behind the store until it retires
    s = idle(); s.ld = 0; s.vin = 1; s.re = 1; s.modrm = 8'h00;
    apply(s);
    s.std = 1; apply(s);
    s.std = 0; apply(s);
    s.ld = 1;  apply(s);

    // RAW on ECX
    s = idle(); s.vin = 1; s.rm = 1; s.modrm = 8'h01; s.dval = 32'hCAFE_0001;
    apply(s);
    s = idle(); s.ld = 0; s.vin = 1; s.ro = 1; s.modrm = 8'h08;
    apply(s); apply(s);
    s.wbv = 1; s.wbrwe = 1; s.wbidx = 3'd1; apply(s);
    s.wbv = 0; s.wbrwe = 0; apply(s);
    s.ld = 1; apply(s);

    // Issue and writeback on the same register: count stays at 1
    s = idle(); s.vin = 1; s.rm = 1; s.modrm = 8'h02; apply(s);
    s.wbv = 1; s.wbrwe = 1; s.wbidx = 3'd2; apply(s);
    s = idle(); s.ld = 0; s.vin = 1; s.ro = 1; s.modrm = 8'h10; apply(s);
    s.wbv = 1; s.wbrwe = 1; s.wbidx = 3'd2; apply(s);
    s.wbv = 0; s.wbrwe = 0; apply(s);

    // Store issue with retire at st_cnt=2 holds the count
    s = idle(); s.vin = 1; s.we = 1; s.modrm = 8'h03; apply(s); apply(s);
    s.std = 1; apply(s);
    s = idle(); s.ld = 0; s.vin = 1; s.re = 1; s.std = 1; apply(s); apply(s);
    s.std = 0; apply(s);

    // Stall holds everything, bubble clears only valid
    s = idle(); s.vin = 1; s.sreg = 16'h1234; s.disp = 32'h0000_0FF0; s.modrm = 8'h06; s.jmp = 3'd5;
    apply(s);
    for (int k = 0; k < 3; k++) begin
      s = rand_stim(); s.ld = 0; s.vin = 1; s.wbv = 0; s.std = 0; apply(s);
    end
    s = idle(); apply(s); apply(s);

    rf_churn = 1'b1;
    for (int k = 0; k < 1500; k++) apply(rand_stim());

    // Drain, then build pend[1]=2 and st_cnt=3 and reset during a stall
    while (st_m > 0) begin s = idle(); s.std = 1; apply(s); end
    for (int i = 0; i < 8; i++) begin
      while (pend_m[i] > 0) begin
        s = idle(); s.wbv = 1; s.wbrwe = 1; s.wbidx = 3'(i); apply(s);
      end
    end
    s = idle(); s.vin = 1; s.rm = 1; s.modrm = 8'h01; apply(s); apply(s);
    s = idle(); s.vin = 1; s.we = 1; s.modrm = 8'h05; repeat (3) apply(s);
    s = idle(); s.ld = 0; s.vin = 1; s.re = 1; s.ro = 1; s.modrm = 8'h0D; apply(s); apply(s);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ag_out", {ag_v, ag_re, ag_we, ag_rmsel, ag_alusel, ag_jmp, ag_modrm,
                         ag_dval, ag_sval, ag_addr}, 128'h0);
    check("rst_reg_dep", reg_dep, 1'b0);
    check("rst_mem_dep", mem_dep, 1'b0);
    check("rst_perf", {perf_regdep, perf_memdep}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 400; k++) apply(rand_stim());
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ag_stage.md
Name: ag_stage

Overview:
- Address-generation stage, directly downstream of decode.
- Latches decoded micro-op fields when decode issues, and computes the linear memory address as segment base + base register + displacement.
- Owns the register scoreboard and the outstanding-store counter, which produce the reg_dep/mem_dep back-pressure signals that decode uses to form ag_vin and ld_ag.
- Feeds the memory-read stage.

Parameters:
- NREG, 8, number of architectural GPRs tracked by the scoreboard (index width 3).
- PEND_W, 2, width of each per-register pending-write counter.
- ST_W, 3, width of the outstanding-store counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ld_ag  in  1  AG latch enable from decode (low = hold)
- ag_vin  in  1  valid micro-op presented by decode
- de_re, de_we, de_rmsel, ro_needed, rm_needed  in  1 each  decoded control bits
- de_alusel  in  2  ALU select
- de_jmp  in  3  jump class
- de_modrm  in  8  ModR/M byte (reg=[5:3], rm=[2:0])
- de_sreg  in  16  segment selector value
- de_dval, de_sval, de_disp  in  32 each  operand values / displacement
- rf_ridx  out  3  regfile read index = de_modrm[2:0] (combinational)
- rf_rdata  in  32  regfile read data for rf_ridx (combinational)
- wb_v, wb_rwe  in  1 each  writeback valid / register-write
- wb_ridx  in  3  writeback register index
- st_done  in  1  one store retired this cycle
- reg_dep, mem_dep  out  1 each  dependency stalls to decode (combinational)
- ag_v  out  1  AG output valid
- ag_re, ag_we, ag_rmsel  out  1 each  latched control
- ag_alusel  out  2
- ag_jmp  out  3
- ag_modrm  out  8
- ag_dval, ag_sval, ag_addr  out  32 each
- perf_regdep, perf_memdep  out  16 each  stall counters (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): all registered outputs 0, all scoreboard counters 0, store counter 0. Reset mid-operation discards any in-flight op and any pending state.
- Issue: issue = ld_ag & ag_vin.
- Issue cycle: on the clock edge, latch all de_* fields into the ag_* outputs, compute ag_addr = {de_sreg,4'h0} + rf_rdata + de_disp (mod 2^32, carry dropped), and set ag_v<=1.
- Latency: one cycle from issue to ag_v.
- Bubble (ld_ag=1, ag_vin=0): ag_v<=0; the data fields hold their previous values.
- Stall (ld_ag=0): every AG register holds, including ag_v. The scoreboard and store counter still process wb/st_done.
- Source registers:
  - src_reg = de_modrm[5:3] when ro_needed.
  - src_rm = de_modrm[2:0] when (rm_needed | de_rmsel).
- Destination register: dst = de_modrm[2:0] when rm_needed & !de_we & !de_rmsel.
- reg_dep = 1 when any of the following holds:
  - the source register counter pend[src_reg] != 0;
  - the source register counter pend[src_rm] != 0;
  - the destination counter is saturated: dst valid and pend[dst] == 2^PEND_W-1.
- Scoreboard update:
  - Increment pend[dst] on issue with a valid dst.
  - Decrement pend[wb_ridx] on wb_v & wb_rwe.
  - Increment and decrement on the same index in the same cycle: counter unchanged.
  - Decrement of a zero counter: counter stays 0 (protocol error, flagged by assertion in the bench).
- Store counter st_cnt:
  - Increment on issue & de_we.
  - Decrement on st_done.
  - Both in the same cycle: unchanged. Underflow holds at 0.
- mem_dep = (de_re & st_cnt != 0) | (de_we & st_cnt == 2^ST_W-1). Loads wait for all older stores to drain; stores stop issuing at counter full.
- reg_dep and mem_dep are combinational on de_* fields and current state only. They must not depend on ld_ag or ag_vin, so no combinational loop with decode.
- rf_ridx is a pure wire from de_modrm[2:0].

Optional Feature:
- Macro: AG_PERF_CNT_EN.
- Defined:
  - perf_regdep increments each cycle reg_dep=1; perf_memdep increments each cycle mem_dep=1.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: both ports driven constant 0 and no counter flops are instantiated.

Test Plan:
- Reset then single issue: de_sreg=16'h0001, rf_rdata=32'h00000010, de_disp=32'h00000001, de_we=1 -> ag_v=1 one cycle later, ag_addr=32'h00000021, st_cnt=1.
- RAW register hazard: issue a dst=ECX(rm=3'b001) register-write op; next op has ro_needed with modrm[5:3]=3'b001 -> reg_dep=1 until wb_v=1, wb_rwe=1, wb_ridx=1; reg_dep=0 the following cycle.
- Store-then-load: store issues (st_cnt=1), then a de_re=1 op is presented -> mem_dep=1; pulse st_done -> mem_dep=0 the next cycle.
- Simultaneous issue with wb to the same reg while pend=1 -> pend stays 1. Simultaneous store issue with st_done while st_cnt=2 -> st_cnt stays 2.
- Stall/bubble: ld_ag=0 for 3 cycles with ag_vin=1 -> all ag_* outputs unchanged. Then ld_ag=1, ag_vin=0 -> ag_v=0 and ag_addr holds.
- Async reset asserted mid-stall with pend[1]=2 and st_cnt=3 -> outputs 0 immediately, reg_dep=mem_dep=0. With AG_PERF_CNT_EN, perf_memdep=0.
